// File: rtl/drm_sdp_arbiter_if.sv
// Requester-side bundle for the DRM simple-dual-port arbiter.
// One instance per requester: request handshake plus read response.
`timescale 1ns/1ps
interface drm_sdp_arbiter_if #(
  parameter int AW   = 14,
  parameter int DW   = 32,
  parameter int BE_W = DW/8
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [BE_W-1:0] req_be;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/drm_sdp_arbiter.sv
// Two-requester arbiter for a simple-dual-port DRM: parallel read/write
// issue, round-robin on same-type conflicts, read-owner tag tracking.
`timescale 1ns/1ps
module drm_sdp_arbiter #(
  parameter int AW         = 14,
  parameter int DW         = 32,
  parameter int BE_W       = DW/8,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  drm_sdp_arbiter_if.slave a_if,
  drm_sdp_arbiter_if.slave b_if,
  output logic             o_ram_wr_en,
  output logic             o_ram_wr_clk_en,
  output logic [AW-1:0]    o_ram_wr_addr,
  output logic [DW-1:0]    o_ram_wr_data,
  output logic [BE_W-1:0]  o_ram_wr_byte_en,
  output logic [AW-1:0]    o_ram_rd_addr,
  input  logic [DW-1:0]    i_ram_rd_data
);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } own_e;

  own_e                  r_rr_ptr;
  logic [AW-1:0]         r_rd_addr;
  logic [RD_LATENCY-1:0] r_tag_v;
  logic [RD_LATENCY-1:0] r_tag_id;

  logic w_a_v;
  logic w_b_v;
  logic w_both;
  logic w_mixed;
  logic w_same_addr;
  logic w_gnt_a;
  logic w_gnt_b;
  logic w_rr_adv;
  logic w_wr_a;
  logic w_wr_b;
  logic w_rd_a;
  logic w_rd_b;
  logic w_rd_any;
  logic w_tag_out;

  assign w_a_v       = a_if.req_valid & ~rst;
  assign w_b_v       = b_if.req_valid & ~rst;
  assign w_both      = w_a_v & w_b_v;
  assign w_mixed     = w_both & (a_if.req_we ^ b_if.req_we);
  assign w_same_addr = (a_if.req_addr == b_if.req_addr);

  // Same-address read/write pair: writer wins so the reader sees new data
  always_comb begin
    w_gnt_a  = 1'b0;
    w_gnt_b  = 1'b0;
    w_rr_adv = 1'b0;
    unique case (1'b1)
      (w_a_v & ~w_b_v): w_gnt_a = 1'b1;
      (~w_a_v & w_b_v): w_gnt_b = 1'b1;
      w_mixed: begin
        w_gnt_a = a_if.req_we | ~w_same_addr;
        w_gnt_b = b_if.req_we | ~w_same_addr;
      end
      (w_both & ~w_mixed): begin
        w_gnt_a  = (r_rr_ptr == OWN_A);
        w_gnt_b  = (r_rr_ptr == OWN_B);
        w_rr_adv = 1'b1;
      end
      default: ;
    endcase
  end

  assign a_if.req_ready = w_gnt_a;
  assign b_if.req_ready = w_gnt_b;

  assign w_wr_a   = w_gnt_a & a_if.req_we;
  assign w_wr_b   = w_gnt_b & b_if.req_we;
  assign w_rd_a   = w_gnt_a & ~a_if.req_we;
  assign w_rd_b   = w_gnt_b & ~b_if.req_we;
  assign w_rd_any = w_rd_a | w_rd_b;

  assign o_ram_wr_en      = w_wr_a | w_wr_b;
  assign o_ram_wr_clk_en  = w_wr_a | w_wr_b;
  assign o_ram_wr_addr    = w_wr_b ? b_if.req_addr  : a_if.req_addr;
  assign o_ram_wr_data    = w_wr_b ? b_if.req_wdata : a_if.req_wdata;
  assign o_ram_wr_byte_en = w_wr_b ? b_if.req_be    : a_if.req_be;

  always_comb begin
    o_ram_rd_addr = r_rd_addr;
    if (w_rd_b)
      o_ram_rd_addr = b_if.req_addr;
    else if (w_rd_a)
      o_ram_rd_addr = a_if.req_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= OWN_A;
      r_rd_addr <= '0;
    end else begin
      if (w_rr_adv)
        r_rr_ptr <= (r_rr_ptr == OWN_A) ? OWN_B : OWN_A;
      if (w_rd_any)
        r_rd_addr <= o_ram_rd_addr;
    end
  end

  // Owner tags ride alongside the RAM read pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v[0]  <= w_rd_any;
      r_tag_id[0] <= w_rd_b;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  assign w_tag_out = r_tag_v[RD_LATENCY-1] & ~rst;

  assign a_if.rsp_valid = w_tag_out & ~r_tag_id[RD_LATENCY-1];
  assign b_if.rsp_valid = w_tag_out &  r_tag_id[RD_LATENCY-1];
  assign a_if.rsp_rdata = i_ram_rd_data;
  assign b_if.rsp_rdata = i_ram_rd_data;

endmodule

// File: tb/tb_drm_sdp_arbiter.sv
// Directed bench for drm_sdp_arbiter: one DUT at RD_LATENCY=1,
// one at RD_LATENCY=2, each behind a byte-enabled RAM model.
`timescale 1ns/1ps
module tb_drm_sdp_arbiter;
  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int BE_W = 4;
  localparam int NW   = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  drm_sdp_arbiter_if #(AW, DW, BE_W) a0 ();
  drm_sdp_arbiter_if #(AW, DW, BE_W) b0 ();
  drm_sdp_arbiter_if #(AW, DW, BE_W) a1 ();
  drm_sdp_arbiter_if #(AW, DW, BE_W) b1 ();

  logic            w0_wr_en, w0_wr_ce, w1_wr_en, w1_wr_ce;
  logic [AW-1:0]   w0_wr_addr, w0_rd_addr, w1_wr_addr, w1_rd_addr;
  logic [DW-1:0]   w0_wr_data, w0_rd_data, w1_wr_data, w1_rd_data;
  logic [BE_W-1:0] w0_be, w1_be;

  drm_sdp_arbiter #(.AW(AW), .DW(DW), .BE_W(BE_W), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .a_if(a0), .b_if(b0),
    .o_ram_wr_en(w0_wr_en), .o_ram_wr_clk_en(w0_wr_ce),
    .o_ram_wr_addr(w0_wr_addr), .o_ram_wr_data(w0_wr_data),
    .o_ram_wr_byte_en(w0_be), .o_ram_rd_addr(w0_rd_addr),
    .i_ram_rd_data(w0_rd_data)
  );

  drm_sdp_arbiter #(.AW(AW), .DW(DW), .BE_W(BE_W), .RD_LATENCY(2)) u_dut1 (
    .clk(clk), .rst(rst), .a_if(a1), .b_if(b1),
    .o_ram_wr_en(w1_wr_en), .o_ram_wr_clk_en(w1_wr_ce),
    .o_ram_wr_addr(w1_wr_addr), .o_ram_wr_data(w1_wr_data),
    .o_ram_wr_byte_en(w1_be), .o_ram_rd_addr(w1_rd_addr),
    .i_ram_rd_data(w1_rd_data)
  );

  // RAM models: untouched word at address n reads 0xC0DE0000|n
  logic [DW-1:0] mem0 [NW];
  logic [DW-1:0] mem1 [NW];
  bit            m0_init, m1_init;
  logic [DW-1:0] r0_q1, r1_q1, r1_q2;

  always @(posedge clk) begin
    if (!m0_init) begin
      for (int i = 0; i < NW; i++) mem0[i] = 32'hC0DE0000 | 32'(i);
      m0_init = 1'b1;
    end
    r0_q1 <= mem0[w0_rd_addr];
    if (w0_wr_en)
      for (int k = 0; k < BE_W; k++)
        if (w0_be[k]) mem0[w0_wr_addr][8*k +: 8] = w0_wr_data[8*k +: 8];
  end

  always @(posedge clk) begin
    if (!m1_init) begin
      for (int i = 0; i < NW; i++) mem1[i] = 32'hC0DE0000 | 32'(i);
      m1_init = 1'b1;
    end
    r1_q1 <= mem1[w1_rd_addr];
    r1_q2 <= r1_q1;
    if (w1_wr_en)
      for (int k = 0; k < BE_W; k++)
        if (w1_be[k]) mem1[w1_wr_addr][8*k +: 8] = w1_wr_data[8*k +: 8];
  end

  assign w0_rd_data = r0_q1;
  assign w1_rd_data = r1_q2;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drv(input int sel, input int v, input int we,
                     input int addr, input logic [31:0] d, input int be);
    case (sel)
      0: begin
        a0.req_valid = (v != 0); a0.req_we = (we != 0);
        a0.req_addr = AW'(addr); a0.req_wdata = d; a0.req_be = BE_W'(be);
      end
      1: begin
        b0.req_valid = (v != 0); b0.req_we = (we != 0);
        b0.req_addr = AW'(addr); b0.req_wdata = d; b0.req_be = BE_W'(be);
      end
      2: begin
        a1.req_valid = (v != 0); a1.req_we = (we != 0);
        a1.req_addr = AW'(addr); a1.req_wdata = d; a1.req_be = BE_W'(be);
      end
      default: begin
        b1.req_valid = (v != 0); b1.req_we = (we != 0);
        b1.req_addr = AW'(addr); b1.req_wdata = d; b1.req_be = BE_W'(be);
      end
    endcase
  endtask

  task automatic idle();
    for (int s = 0; s < 4; s++) drv(s, 0, 0, 0, 32'h0, 0);
  endtask

  int na, nb, ra, rb, paddr;
  bit pa_own;

  initial begin
    rst = 1'b1;
    idle();
    drv(0, 1, 1, 'h10, 32'h1, 'hF);
    repeat (2) @(negedge clk);
    #1;
    check("rst a_ready", 32'(a0.req_ready), 0);
    check("rst wr_en", 32'(w0_wr_en), 0);
    check("rst rd_addr", 32'(w0_rd_addr), 0);
    check("rst a_rsp", 32'(a0.rsp_valid), 0);

    @(negedge clk);
    rst = 1'b0;
    idle();

    // write then read back
    @(negedge clk);
    drv(0, 1, 1, 'h10, 32'hDEADBEEF, 'hF);
    #1;
    check("wr a_ready", 32'(a0.req_ready), 1);
    check("wr en", 32'(w0_wr_en), 1);
    check("wr clk_en", 32'(w0_wr_ce), 1);
    check("wr addr", 32'(w0_wr_addr), 'h10);
    check("wr data", w0_wr_data, 32'hDEADBEEF);
    check("wr be", 32'(w0_be), 'hF);
    @(negedge clk);
    drv(0, 1, 0, 'h10, 32'h0, 0);
    #1;
    check("rd a_ready", 32'(a0.req_ready), 1);
    check("rd addr", 32'(w0_rd_addr), 'h10);
    check("rd no wr", 32'(w0_wr_en), 0);
    @(negedge clk);
    idle();
    #1;
    check("rd a_rsp", 32'(a0.rsp_valid), 1);
    check("rd a_data", a0.rsp_rdata, 32'hDEADBEEF);
    check("rd b_rsp", 32'(b0.rsp_valid), 0);
    @(negedge clk);
    #1;
    check("rd a_rsp 1cyc", 32'(a0.rsp_valid), 0);
    check("rd addr hold", 32'(w0_rd_addr), 'h10);

    // byte enables
    @(negedge clk);
    drv(0, 1, 1, 'h20, 32'h11223344, 'hF);
    @(negedge clk);
    drv(0, 1, 1, 'h20, 32'hAABBCCDD, 'h5);
    @(negedge clk);
    drv(0, 1, 0, 'h20, 32'h0, 0);
    @(negedge clk);
    idle();
    #1;
    check("be rsp", 32'(a0.rsp_valid), 1);
    check("be data", a0.rsp_rdata, 32'h11BB33DD);

    // contested reads alternate A,B,...
    na = 0; nb = 0; ra = 0; rb = 0; paddr = 0; pa_own = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 8) begin
        drv(0, 1, 0, 'h100 + na, 32'h0, 0);
        drv(1, 1, 0, 'h200 + nb, 32'h0, 0);
      end else begin
        idle();
      end
      #1;
      if (c > 0) begin
        check("rr a_rsp", 32'(a0.rsp_valid), 32'(pa_own));
        check("rr b_rsp", 32'(b0.rsp_valid), 32'(!pa_own));
        check("rr data", w0_rd_data, 32'hC0DE0000 | 32'(paddr));
        if (a0.rsp_valid) ra++;
        if (b0.rsp_valid) rb++;
      end
      if (c < 8) begin
        check("rr a_ready", 32'(a0.req_ready), 32'(c % 2 == 0));
        check("rr b_ready", 32'(b0.req_ready), 32'(c % 2 == 1));
        pa_own = (c % 2 == 0);
        if (pa_own) begin
          paddr = 'h100 + na; na++;
        end else begin
          paddr = 'h200 + nb; nb++;
        end
      end
    end
    check("rr a_count", 32'(ra), 4);
    check("rr b_count", 32'(rb), 4);

    // read/write pairs: distinct vs same address
    @(negedge clk);
    drv(0, 1, 1, 'h30, 32'h55AA55AA, 'hF);
    drv(1, 1, 0, 'h40, 32'h0, 0);
    #1;
    check("pair a_ready", 32'(a0.req_ready), 1);
    check("pair b_ready", 32'(b0.req_ready), 1);
    check("pair wr_addr", 32'(w0_wr_addr), 'h30);
    check("pair rd_addr", 32'(w0_rd_addr), 'h40);
    @(negedge clk);
    drv(0, 1, 1, 'h30, 32'h12345678, 'hF);
    drv(1, 1, 0, 'h30, 32'h0, 0);
    #1;
    check("pair b_rsp", 32'(b0.rsp_valid), 1);
    check("pair b_data", b0.rsp_rdata, 32'hC0DE0040);
    check("hit a_ready", 32'(a0.req_ready), 1);
    check("hit b_ready", 32'(b0.req_ready), 0);
    check("hit wr_en", 32'(w0_wr_en), 1);
    @(negedge clk);
    drv(0, 0, 0, 0, 32'h0, 0);
    #1;
    check("retry b_ready", 32'(b0.req_ready), 1);
    check("retry rd_addr", 32'(w0_rd_addr), 'h30);
    check("retry no rsp", 32'(b0.rsp_valid), 0);
    @(negedge clk);
    idle();
    #1;
    check("retry b_rsp", 32'(b0.rsp_valid), 1);
    check("retry b_data", b0.rsp_rdata, 32'h12345678);

    // reset with a read in flight, rr pointer parked on B
    @(negedge clk);
    drv(0, 1, 0, 'h60, 32'h0, 0);
    drv(1, 1, 0, 'h61, 32'h0, 0);
    #1;
    check("pre a_ready", 32'(a0.req_ready), 1);
    check("pre b_ready", 32'(b0.req_ready), 0);
    @(negedge clk);
    drv(0, 1, 0, 'h50, 32'h0, 0);
    drv(1, 0, 0, 0, 32'h0, 0);
    #1;
    check("fly a_ready", 32'(a0.req_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    drv(0, 1, 1, 'h70, 32'hFFFFFFFF, 'hF);
    #1;
    check("mid-rst a_rsp", 32'(a0.rsp_valid), 0);
    check("mid-rst wr_en", 32'(w0_wr_en), 0);
    check("mid-rst a_ready", 32'(a0.req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    check("post-rst a_rsp", 32'(a0.rsp_valid), 0);
    check("post-rst b_rsp", 32'(b0.rsp_valid), 0);
    @(negedge clk);
    drv(0, 1, 0, 'h80, 32'h0, 0);
    drv(1, 1, 0, 'h81, 32'h0, 0);
    #1;
    check("post-rst rr a", 32'(a0.req_ready), 1);
    check("post-rst rr b", 32'(b0.req_ready), 0);
    @(negedge clk);
    idle();

    // RD_LATENCY=2: A,B,A back to back
    @(negedge clk);
    drv(2, 1, 0, 'h300, 32'h0, 0);
    #1;
    check("l2 a_ready", 32'(a1.req_ready), 1);
    @(negedge clk);
    drv(2, 0, 0, 0, 32'h0, 0);
    drv(3, 1, 0, 'h301, 32'h0, 0);
    #1;
    check("l2 b_ready", 32'(b1.req_ready), 1);
    check("l2 a_rsp early", 32'(a1.rsp_valid), 0);
    @(negedge clk);
    drv(2, 1, 0, 'h302, 32'h0, 0);
    drv(3, 0, 0, 0, 32'h0, 0);
    #1;
    check("l2 a_rsp0", 32'(a1.rsp_valid), 1);
    check("l2 a_data0", a1.rsp_rdata, 32'hC0DE0300);
    check("l2 b_rsp0", 32'(b1.rsp_valid), 0);
    @(negedge clk);
    idle();
    #1;
    check("l2 b_rsp1", 32'(b1.rsp_valid), 1);
    check("l2 b_data1", b1.rsp_rdata, 32'hC0DE0301);
    check("l2 a_rsp1", 32'(a1.rsp_valid), 0);
    @(negedge clk);
    #1;
    check("l2 a_rsp2", 32'(a1.rsp_valid), 1);
    check("l2 a_data2", a1.rsp_rdata, 32'hC0DE0302);
    @(negedge clk);
    #1;
    check("l2 a_rsp end", 32'(a1.rsp_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
